// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming code sizes, receive FSM states and counter width helpers.
package hamming_pkg;
   localparam int P_DEF = 3;
   function automatic int n_of(input int p);
      return 2**p - 1;
   endfunction
   function automatic int k_of(input int p);
      return 2**p - 1 - p;
   endfunction
   function automatic int cnt_w(input int p);
      return $clog2(2**p - 1);
   endfunction
   typedef enum logic {HUNT, COLLECT} state_e;
endpackage

// File: rtl/hamming_rx_deserializer.sv
// hamming_rx_deserializer: assembles serial LSB-first bits into N-bit codewords behind a valid/ready register.
module hamming_rx_deserializer
   import hamming_pkg::*;
#(
   parameter int P = P_DEF,
   localparam int N = n_of(P),
   localparam int CW = cnt_w(P)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_in,
   input  logic         bit_valid,
   input  logic         sof,
   output logic [N-1:0] cw_data,
   output logic         cw_valid,
   input  logic         cw_ready,
   output logic         overflow,
   output logic         resync,
   input  logic         clear_flags
);
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0] shift_q, shift_d, cw_data_q, cw_data_d;
   logic cw_valid_q, cw_valid_d, overflow_q, overflow_d, resync_q, resync_d, done;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      shift_d = shift_q;
      cw_data_d = cw_data_q;
      cw_valid_d = cw_valid_q & ~cw_ready;
      overflow_d = overflow_q & ~clear_flags;
      resync_d = resync_q & ~clear_flags;
      done = 1'b0;
      if (bit_valid && sof) begin
         if (state_q == COLLECT && cnt_q != '0) resync_d = 1'b1;
         shift_d = {{(N-1){1'b0}}, bit_in};
         cnt_d = CW'(1);
         state_d = COLLECT;
      end else if (bit_valid && state_q == COLLECT) begin
         shift_d[cnt_q] = bit_in;
         done = (cnt_q == CW'(N-1));
         cnt_d = done ? '0 : cnt_q + 1'b1;
      end
      // The completed word bypasses shift_q so it lands in the slot on the same edge as its last bit.
      if (done) begin
         if (!cw_valid_q || cw_ready) begin
            cw_data_d = shift_d;
            cw_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         cnt_q <= '0;
         shift_q <= '0;
         cw_data_q <= '0;
         cw_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         resync_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         shift_q <= shift_d;
         cw_data_q <= cw_data_d;
         cw_valid_q <= cw_valid_d;
         overflow_q <= overflow_d;
         resync_q <= resync_d;
      end
   end
   assign cw_data = cw_data_q;
   assign cw_valid = cw_valid_q;
   assign overflow = overflow_q;
   assign resync = resync_q;
endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// tb_hamming_rx_deserializer: directed scenario tasks for the serial-to-codeword receive stage.
module tb_hamming_rx_deserializer;
   logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0;
   logic cw_ready = 1'b1, clear_flags = 1'b0;
   logic [6:0] cw_data;
   logic cw_valid, overflow, resync;
   int checks = 0, errors = 0;

   hamming_rx_deserializer dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
      .overflow(overflow), .resync(resync), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   task automatic send_bit(input logic b, input logic s);
      bit_in = b;
      bit_valid = 1'b1;
      sof = s;
      @(negedge clk);
      bit_valid = 1'b0;
      sof = 1'b0;
   endtask

   task automatic send_word(input logic [6:0] w, input logic s);
      for (int i = 0; i < 7; i++) send_bit(w[i], s && i == 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({cw_data, cw_valid, overflow, resync} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, want 0", {cw_data, cw_valid, overflow, resync});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame55();
      cw_ready = 1'b1;
      for (int i = 0; i < 6; i++) send_bit(~i[0], i == 0);
      checks++;
      if (cw_valid !== 1'b0) begin errors++; $display("FAIL f55_early_valid: got %b, want 0", cw_valid); end
      send_bit(1'b1, 1'b0);
      checks++;
      if (cw_valid !== 1'b1 || cw_data !== 7'h55) begin
         errors++; $display("FAIL f55_word: valid %b data %h, want 1 55", cw_valid, cw_data);
      end
      checks++;
      if (overflow !== 1'b0 || resync !== 1'b0) begin
         errors++; $display("FAIL f55_flags: ovf %b rsy %b, want 0 0", overflow, resync);
      end
      @(negedge clk);
      checks++;
      if (cw_valid !== 1'b0) begin errors++; $display("FAIL f55_accept: valid %b, want 0", cw_valid); end
   endtask

   task automatic test_back_to_back();
      logic [13:0] stream;
      stream = {7'h7F, 7'h55};
      cw_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bit_in = stream[i];
         bit_valid = 1'b1;
         sof = 1'b0;
         @(negedge clk);
         if (i == 6) begin
            checks++;
            if (cw_valid !== 1'b1 || cw_data !== 7'h55) begin
               errors++; $display("FAIL b2b_first: valid %b data %h, want 1 55", cw_valid, cw_data);
            end
         end else if (i == 13) begin
            checks++;
            if (cw_valid !== 1'b1 || cw_data !== 7'h7F) begin
               errors++; $display("FAIL b2b_second: valid %b data %h, want 1 7f", cw_valid, cw_data);
            end
         end else if (i > 6) begin
            checks++;
            if (cw_valid !== 1'b0) begin
               errors++; $display("FAIL b2b_gap_valid cycle %0d: valid %b, want 0", i, cw_valid);
            end
         end
      end
      bit_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_overflow();
      cw_ready = 1'b0;
      send_word(7'h55, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_premature: ovf %b, want 0", overflow); end
      send_word(7'h00, 1'b0);
      checks++;
      if (cw_valid !== 1'b1 || cw_data !== 7'h55 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_hold: valid %b data %h ovf %b, want 1 55 1", cw_valid, cw_data, overflow);
      end
      cw_ready = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (cw_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: valid %b, want 0", cw_valid); end
   endtask

   task automatic test_resync();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf: ovf %b, want 0", overflow); end
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_word(7'h7F, 1'b1);
      checks++;
      if (resync !== 1'b1 || cw_valid !== 1'b1 || cw_data !== 7'h7F) begin
         errors++; $display("FAIL resync_word: rsy %b valid %b data %h, want 1 1 7f", resync, cw_valid, cw_data);
      end
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      checks++;
      if (resync !== 1'b0 || cw_valid !== 1'b0) begin
         errors++; $display("FAIL resync_clear: rsy %b valid %b, want 0 0", resync, cw_valid);
      end
   endtask

   task automatic test_gaps_hunt();
      logic [6:0] w;
      w = 7'h55;
      do_reset();
      for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
      checks++;
      if (cw_valid !== 1'b0) begin errors++; $display("FAIL hunt_ignore: valid %b, want 0", cw_valid); end
      for (int i = 0; i < 7; i++) begin
         send_bit(w[i], i == 0);
         repeat ($urandom_range(0, 3)) begin
            bit_in = 1'($urandom);
            sof = 1'b1;
            @(negedge clk);
         end
         sof = 1'b0;
         if (i < 6) begin
            checks++;
            if (cw_valid !== 1'b0) begin errors++; $display("FAIL gap_early bit %0d: valid %b, want 0", i, cw_valid); end
         end
      end
      checks++;
      if (cw_data !== 7'h55 || resync !== 1'b0) begin
         errors++; $display("FAIL gap_word: data %h rsy %b, want 55 0", cw_data, resync);
      end
   endtask

   task automatic test_reset_midword();
      cw_ready = 1'b0;
      send_word(7'h2A, 1'b1);
      send_word(7'h00, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({cw_data, cw_valid, overflow, resync} !== 10'd0) begin
         errors++; $display("FAIL midreset_outputs: got %h, want 0", {cw_data, cw_valid, overflow, resync});
      end
      @(negedge clk);
      rst = 1'b0;
      cw_ready = 1'b1;
      send_word(7'h00, 1'b1);
      checks++;
      if (cw_valid !== 1'b1 || cw_data !== 7'h00 || resync !== 1'b0) begin
         errors++; $display("FAIL midreset_word: valid %b data %h rsy %b, want 1 00 0", cw_valid, cw_data, resync);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (cw_valid !== 1'b0) begin errors++; $display("FAIL midreset_single: valid %b, want 0", cw_valid); end
   endtask

   initial begin
      test_reset();
      test_frame55();
      test_back_to_back();
      test_overflow();
      test_resync();
      test_gaps_hunt();
      test_reset_midword();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
